// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline without forwarding.
// Detects RAW hazards against EX and MEM and inserts bubbles for them.
// Squashes wrong-path fetches after a redirect, freezes on data-memory wait,
// and keeps saturating debug counters for stalls and redirects.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W     = 6,
   parameter int unsigned FETCH_LAT = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_reg_write,
   input  logic             redirect,
   input  logic             mem_wait,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             hazard_stall,
   output logic             flushing,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [0:0] {StRun, StFlush} state_t;

   localparam logic [3:0]       LatCnt = 4'(FETCH_LAT);
   localparam logic [CNT_W-1:0] CntMax = '1;

   state_t           state_q;
   logic [3:0]       fcnt_q;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   logic             raw;

   // A source operand conflicts if a pending writer in EX or MEM targets it; r0 never does.
   function automatic logic match(input logic [REG_W-1:0] r);
      return (r != '0) && ((ex_reg_write && (ex_rd == r)) || (mem_reg_write && (mem_rd == r)));
   endfunction

   assign raw = (id_use_rs && match(id_rs)) || (id_use_rt && match(id_rt));

   assign flushing    = (state_q == StFlush);
   assign stall_count = stall_q;
   assign flush_count = flush_q;

   // Pipeline control decode; priority reset > freeze > redirect > flush > RAW > run.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      hazard_stall = 1'b0;
      if (!rst_n) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (mem_wait) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
      end else if (redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state_q == StFlush) begin
         // ID holds squashed NOPs here, so raw is deliberately ignored.
         if_id_flush = 1'b1;
      end else if (raw) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_flush  = 1'b1;
         hazard_stall = 1'b1;
      end
   end

   // FSM, flush countdown and saturating event counters; all hold while frozen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StRun;
         fcnt_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else if (!mem_wait) begin
         if (redirect) begin
            if (flush_q != CntMax) flush_q <= flush_q + 1'b1;
            fcnt_q  <= LatCnt;
            state_q <= (LatCnt != 4'd0) ? StFlush : StRun;
         end else if (state_q == StFlush) begin
            fcnt_q <= fcnt_q - 4'd1;
            if (fcnt_q <= 4'd1) state_q <= StRun;
         end else if (raw) begin
            if (stall_q != CntMax) stall_q <= stall_q + 1'b1;
         end
      end
   end

   // The flush countdown is only 4 bits wide.
   always_ff @(posedge clk) begin
      assert (FETCH_LAT <= 15) else $error("pipe_hazard_ctrl: FETCH_LAT %0d exceeds 15", FETCH_LAT);
   end

endmodule
